// File: rtl/washer_pkg.sv
// Shared state encoding for the washing machine sequencer.
package washer_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_FILL      = 3'd1;
   localparam state_t ST_DETERGENT = 3'd2;
   localparam state_t ST_WASH      = 3'd3;
   localparam state_t ST_DRAIN     = 3'd4;
   localparam state_t ST_SPIN      = 3'd5;
   localparam state_t ST_DONE      = 3'd6;

endpackage

// File: rtl/washing_machine.sv
// Moore sequencer for one wash program: fill, detergent, wash, drain, rinse, spin, done.
//
//  state     | meaning
//  ----------+----------------------------------------------------------
//  IDLE      | waiting for start with the door closed
//  FILL      | inlet valve open until the drum reaches level
//  DETERGENT | waiting for the dispenser (first pass only)
//  WASH      | agitation, soap wash or rinse depending on the flags
//  DRAIN     | pump running until the drum is empty
//  SPIN      | final spin with the pump on
//  DONE      | program complete, door released, wait for door to open
module washing_machine
   import washer_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic door_close,
   input  logic start,
   input  logic filled,
   input  logic detergent_added,
   input  logic cycle_timeout,
   input  logic drained,
   input  logic spin_timeout,
   output logic door_lock,
   output logic motor_on,
   output logic fill_valve_on,
   output logic drain_valve_on,
   output logic done,
   output logic soap_wash,
   output logic water_wash
);

   state_t state;
   logic   soap_flag;
   logic   water_flag;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         soap_flag  <= 1'b0;
         water_flag <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start && door_close) state <= ST_FILL;
            end
            ST_FILL: begin
               if (filled) begin
                  // a second fill after the soap wash is the rinse
                  if (soap_flag) begin
                     state      <= ST_WASH;
                     water_flag <= 1'b1;
                  end else begin
                     state <= ST_DETERGENT;
                  end
               end
            end
            ST_DETERGENT: begin
               if (detergent_added) begin
                  state     <= ST_WASH;
                  soap_flag <= 1'b1;
               end
            end
            ST_WASH: begin
               if (cycle_timeout) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (drained) state <= water_flag ? ST_SPIN : ST_FILL;
            end
            ST_SPIN: begin
               if (spin_timeout) state <= ST_DONE;
            end
            ST_DONE: begin
               if (!door_close) begin
                  state      <= ST_IDLE;
                  soap_flag  <= 1'b0;
                  water_flag <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      door_lock      = 1'b0;
      motor_on       = 1'b0;
      fill_valve_on  = 1'b0;
      drain_valve_on = 1'b0;
      done           = 1'b0;
      case (state)
         ST_FILL: begin
            door_lock     = 1'b1;
            fill_valve_on = 1'b1;
         end
         ST_DETERGENT: door_lock = 1'b1;
         ST_WASH: begin
            door_lock = 1'b1;
            motor_on  = 1'b1;
         end
         ST_DRAIN: begin
            door_lock      = 1'b1;
            drain_valve_on = 1'b1;
         end
         ST_SPIN: begin
            door_lock      = 1'b1;
            motor_on       = 1'b1;
            drain_valve_on = 1'b1;
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   assign soap_wash  = soap_flag;
   assign water_wash = water_flag;

endmodule

// File: tb/tb_washing_machine.sv
// Scoreboard bench for the washing machine sequencer: stimulus queues expected outputs, monitor compares.
module tb_washing_machine;

   logic clk = 1'b0;
   logic reset;
   logic door_close, start, filled, detergent_added, cycle_timeout, drained, spin_timeout;
   logic door_lock, motor_on, fill_valve_on, drain_valve_on, done, soap_wash, water_wash;

   washing_machine dut (
      .clk            (clk),
      .reset          (reset),
      .door_close     (door_close),
      .start          (start),
      .filled         (filled),
      .detergent_added(detergent_added),
      .cycle_timeout  (cycle_timeout),
      .drained        (drained),
      .spin_timeout   (spin_timeout),
      .door_lock      (door_lock),
      .motor_on       (motor_on),
      .fill_valve_on  (fill_valve_on),
      .drain_valve_on (drain_valve_on),
      .done           (done),
      .soap_wash      (soap_wash),
      .water_wash     (water_wash)
   );

   always #5 clk = ~clk;

   // {door_lock, motor_on, fill_valve_on, drain_valve_on, done, soap_wash, water_wash}
   localparam logic [6:0] E_IDLE     = 7'b0000000;
   localparam logic [6:0] E_FILL     = 7'b1010000;
   localparam logic [6:0] E_DET      = 7'b1000000;
   localparam logic [6:0] E_WASH_S   = 7'b1100010;
   localparam logic [6:0] E_DRAIN_S  = 7'b1001010;
   localparam logic [6:0] E_FILL_S   = 7'b1010010;
   localparam logic [6:0] E_WASH_SW  = 7'b1100011;
   localparam logic [6:0] E_DRAIN_SW = 7'b1001011;
   localparam logic [6:0] E_SPIN_SW  = 7'b1101011;
   localparam logic [6:0] E_DONE_SW  = 7'b0000111;

   logic [6:0] exp_q[$];
   string      name_q[$];
   event       chk_ev;
   int         errors = 0;
   int         checks = 0;

   wire [6:0] act = {door_lock, motor_on, fill_valve_on, drain_valve_on, done, soap_wash, water_wash};

   task automatic push(input string name, input logic [6:0] e);
      exp_q.push_back(e);
      name_q.push_back(name);
   endtask

   // wait for the next rising edge, then queue what the outputs must show after it
   task automatic tick_expect(input string name, input logic [6:0] e);
      @(posedge clk);
      #1;
      push(name, e);
   endtask

   initial begin : monitor
      logic [6:0] e;
      string      n;
      forever begin
         @(negedge clk or chk_ev);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (act !== e) begin
               errors++;
               $display("FAIL %s: got %b want %b (lock motor fill drain done soap water) t=%0t",
                        n, act, e, $time);
            end
         end
      end
   end

   initial begin : stimulus
      reset = 1'b1;
      door_close = 1'b0; start = 1'b0; filled = 1'b0; detergent_added = 1'b0;
      cycle_timeout = 1'b0; drained = 1'b0; spin_timeout = 1'b0;

      // 1: reset
      #5 reset = 1'b0;
      #1 push("reset", E_IDLE);

      // 2: full program with inputs raised in turn and held
      #4 start = 1'b1; door_close = 1'b1;
      tick_expect("fill1", E_FILL);
      #4 filled = 1'b1;
      tick_expect("detergent", E_DET);
      #4 detergent_added = 1'b1;
      tick_expect("soap_wash", E_WASH_S);
      #4 cycle_timeout = 1'b1;
      tick_expect("drain1", E_DRAIN_S);
      #4 drained = 1'b1;
      tick_expect("refill", E_FILL_S);
      #4 spin_timeout = 1'b1;
      tick_expect("rinse", E_WASH_SW);
      tick_expect("drain2", E_DRAIN_SW);
      tick_expect("spin", E_SPIN_SW);
      tick_expect("done", E_DONE_SW);
      tick_expect("done_hold_door_shut", E_DONE_SW);

      // 3: open the door in DONE
      #4 start = 1'b0; filled = 1'b0; detergent_added = 1'b0;
      cycle_timeout = 1'b0; drained = 1'b0; spin_timeout = 1'b0;
      door_close = 1'b0;
      tick_expect("done_to_idle", E_IDLE);
      tick_expect("idle_hold", E_IDLE);

      // 4: start with door open is ignored; start dropped in FILL is ignored
      #4 start = 1'b1;
      tick_expect("start_door_open_1", E_IDLE);
      tick_expect("start_door_open_2", E_IDLE);
      #4 door_close = 1'b1;
      tick_expect("fill_after_close", E_FILL);
      #4 start = 1'b0;
      tick_expect("fill_start_dropped_1", E_FILL);
      tick_expect("fill_start_dropped_2", E_FILL);
      #4 filled = 1'b1;
      tick_expect("detergent2", E_DET);
      #4 filled = 1'b0; detergent_added = 1'b1;
      tick_expect("soap_wash2", E_WASH_S);
      #4 detergent_added = 1'b0; door_close = 1'b0;

      // 6: no cycle_timeout for 20 cycles, door opening ignored while locked
      for (int i = 0; i < 20; i++) tick_expect($sformatf("wash_hold_%0d", i), E_WASH_S);

      // 5: asynchronous reset mid-wash, checked before the next clock edge
      @(posedge clk);
      #2 reset = 1'b1;
      #1 push("async_reset", E_IDLE);
      -> chk_ev;
      #1;
      tick_expect("reset_held", E_IDLE);
      #4 reset = 1'b0;
      tick_expect("after_reset", E_IDLE);

      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_queue: got %0d pending want 0", exp_q.size());
      end
      if (checks < 12) begin
         errors++;
         $display("FAIL check_count: got %0d want >= 12", checks);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

endmodule
